// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed driver for an eight-digit common-anode
// seven-segment display.
//
// A 32-bit value is captured into a shadow register on every clock edge where
// load is high, and acknowledged one cycle later on ack. The scanner shows one
// digit at a time. For each digit it runs one BLANK cycle with every digit off
// (this suppresses ghosting), then DIV cycles with that digit lit.
//
// Parameters
//   DIV        DISP cycles per digit, 1 .. 2^24-1
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   disp_num   value to display, nibble 0 = bits[3:0] = rightmost digit
//   load       capture strobe for disp_num
//   ack        one-cycle pulse following each capture
//   an         active-low digit enables, an[0] = rightmost digit
//   seg        active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//
// Compile-time option
//   DISP_SCAN_LZB_EN  when defined, blanks the segments of leading-zero digits
//                     (digit 0 is always shown).

module disp_scan #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_num,
    input  logic        load,
    output logic        ack,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned CNT_W = $clog2(DIV + 1);

    typedef enum logic {
        BLANK = 1'b0,
        DISP  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        shadow_q, shadow_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;

    function automatic logic [7:0] hex_code(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // State register. Reset wins over load, so a reset edge never captures
    // and never acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BLANK;
            shadow_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
        end
    end

    // Next-state logic.
    // The digit index steps when a DISP slot ends rather than when BLANK ends.
    // The index cannot be seen during BLANK, so the displayed sequence is the
    // same either way. This choice lets the first BLANK after reset keep
    // digit 0 without needing an extra "first frame" flag.
    always_comb begin
        state_d  = state_q;
        shadow_d = load ? disp_num : shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_d    = load;

        case (state_q)
            BLANK: begin
                state_d = DISP;
                cnt_d   = '0;
            end
            DISP: begin
                if (cnt_q == CNT_W'(DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode. This uses registered state only.
    always_comb begin
        an  = 8'hFF;
        seg = 8'hFF;
        if (state_q == DISP) begin
            an  = ~(8'h01 << idx_q);
            seg = hex_code(shadow_q[{idx_q, 2'b00} +: 4]);
`ifdef DISP_SCAN_LZB_EN
            // Blank the digit if it and every digit to its left are zero.
            if (idx_q != 3'd0 && (shadow_q >> {idx_q, 2'b00}) == 32'h0)
                seg = 8'hFF;
`endif
        end
    end

    assign ack = ack_q;

endmodule

// File: tb/tb_disp_scan.sv
module tb_disp_scan;

    localparam int unsigned DIV  = 4;
    localparam int unsigned SLOT = DIV + 1;

    logic        clk;
    logic        rst;
    logic [31:0] disp_num;
    logic        load;
    logic        ack;
    logic [7:0]  an;
    logic [7:0]  seg;

    disp_scan #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_num (disp_num),
        .load     (load),
        .ack      (ack),
        .an       (an),
        .seg      (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       ack;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    bit          stim_done = 1'b0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: display timing is derived from the number of cycles
    // elapsed since the last reset edge. The shadow value is held separately.
    int unsigned m_t;
    logic [31:0] m_shadow;
    logic        m_ack;
    int unsigned m_cyc = 0;

    function automatic exp_t predict(int unsigned t, logic [31:0] sh, logic a, int unsigned cyc);
        exp_t e;
        int unsigned pos, dig;
        logic [31:0] upper;
        pos   = t % SLOT;
        dig   = (t / SLOT) % 8;
        e.ack = a;
        e.cyc = cyc;
        if (pos == 0) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            e.an  = 8'hFF;
            e.an[dig] = 1'b0;
            e.seg = hex_tab[(sh >> (4 * dig)) & 32'hF];
`ifdef DISP_SCAN_LZB_EN
            upper = sh >> (4 * dig);
            if (dig != 0 && upper == 32'h0) e.seg = 8'hFF;
`else
            upper = 32'h0;
            if (upper != 32'h0) e.seg = 8'h00;
`endif
        end
        return e;
    endfunction

    // Apply the current inputs to the model as the coming edge will, and
    // record what the DUT must present after that edge.
    task automatic model_edge();
        if (rst) begin
            m_t      = 0;
            m_shadow = 32'h0;
            m_ack    = 1'b0;
        end else begin
            m_t   = m_t + 1;
            m_ack = load;
            if (load) m_shadow = disp_num;
        end
        m_cyc++;
        exp_q.push_back(predict(m_t, m_shadow, m_ack, m_cyc));
    endtask

    task automatic step(input logic r, input logic l, input logic [31:0] d);
        rst      = r;
        load     = l;
        disp_num = d;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
    endtask

    // Monitor: the display outputs are valid every cycle. Each cycle, pop one
    // expectation and compare it against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (an !== e.an) begin
                    n_miss++;
                    $display("FAIL an cyc=%0d got=%02h exp=%02h", e.cyc, an, e.an);
                end
                if (seg !== e.seg) begin
                    n_miss++;
                    $display("FAIL seg cyc=%0d got=%02h exp=%02h", e.cyc, seg, e.seg);
                end
                if (ack !== e.ack) begin
                    n_miss++;
                    $display("FAIL ack cyc=%0d got=%0b exp=%0b", e.cyc, ack, e.ack);
                end
            end
        end
    end

    initial begin
        m_t = 0; m_shadow = 32'h0; m_ack = 1'b0;
        rst = 1'b1; load = 1'b0; disp_num = 32'h0;
        #1;
        // Reset sequence, then one full frame of zeros followed by the wrap.
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hDEADBEEF);
        idle(45);
        // Align to the start of a frame, then load the pattern digit set.
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h1234ABCD);
        idle(44);
        // Mid-slot one-cycle load while digit 0 is lit.
        step(1'b1, 1'b0, 32'h0);
        idle(2);
        step(1'b0, 1'b1, 32'h00000005);
        idle(10);
        // Load held high for several cycles.
        for (int unsigned i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom);
        idle(3);
        // Reset coinciding with load while digit 5 is lit.
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h87654321);
        idle(5 * SLOT + 1);
        step(1'b1, 1'b1, 32'hFFFFFFFF);
        idle(12);
        // Leading-zero cases.
        step(1'b0, 1'b1, 32'h000000A5);
        idle(45);
        step(1'b0, 1'b1, 32'h00000000);
        idle(45);
        step(1'b0, 1'b1, 32'h00F00000);
        idle(45);
        // Randomized traffic: sparse loads with random nibble widths, and rare resets.
        for (int unsigned i = 0; i < 2500; i++) begin
            logic [31:0] v;
            v = $urandom >> (4 * $urandom_range(0, 7));
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), v);
        end
        // Wait until every expectation has been compared, with a cycle bound.
        for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter DIV, default 50000, DISP-state cycles per digit; legal range 1..2^24-1.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 disp_num  input  32  value to display, eight hex nibbles; nibble 0 = bits[3:0].
REQ-005 load  input  1  capture strobe; disp_num sampled on every rising edge where load=1.
REQ-006 ack  output  1  registered one-cycle pulse acknowledging a capture.
REQ-007 an  output  8  active-low digit enables; an[i] selects digit i, rightmost digit = an[0].
REQ-008 seg  output  8  active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp is always 1 (off).

Function
REQ-009 Internal state SHALL be: shadow[31:0], idx[2:0], cnt (width ceil(log2(DIV+1))), and FSM state {BLANK, DISP}.
REQ-010 an and seg SHALL be a combinational decode of the registered state only; they never depend directly on disp_num or load.
REQ-011 BLANK: an=8'hFF, seg=8'hFF; lasts exactly 1 cycle, then goes to DISP with cnt=0.
REQ-012 BLANK->DISP SHALL advance idx by 1 mod 8 (7 wraps to 0), except that the first BLANK after reset keeps idx=0.
REQ-013 DISP: an = all ones except an[idx]=0; seg = hex code of shadow nibble idx; cnt increments each cycle.
REQ-014 DISP with cnt==DIV-1 SHALL go to BLANK on the next edge; each digit slot = DIV+1 cycles; one frame = 8*(DIV+1) cycles.
REQ-015 Hex codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-016 load=1 at edge k SHALL write shadow<=disp_num at edge k; the new value is visible on seg immediately after edge k, with no FSM, idx or cnt disturbance.
REQ-017 ack SHALL be 1 for the single cycle following each edge where load was sampled high; load held high for N cycles gives ack high for N cycles, one cycle delayed.
REQ-018 DIV=1: DISP lasts 1 cycle; slot = 2 cycles.

Reset
REQ-019 rst=1 at an edge SHALL set shadow=0, idx=0, cnt=0, state=BLANK, ack=0; outputs an=FF, seg=FF.
REQ-020 Reset SHALL take priority over load: no capture and no ack.
REQ-021 Reset mid-frame (any state, idx or cnt) SHALL yield the REQ-019 state on the next edge; the frame restarts at digit 0.

Configuration
REQ-022 Macro DISP_SCAN_LZB_EN SHALL select leading-zero blanking at compile time.
REQ-023 With DISP_SCAN_LZB_EN defined: in DISP, digit idx>=1 SHALL output seg=FF (an still active) when shadow nibbles idx..7 are all zero; digit 0 is always shown.
REQ-024 Without DISP_SCAN_LZB_EN: all eight digits SHALL always be decoded per REQ-015; no blanking logic is present.

Verification (DIV=4 unless stated)
REQ-025 Release rst -> first cycle an=FF seg=FF; then 4 cycles an=FE seg=C0; then 1 cycle an=FF seg=FF; then an=FD.
REQ-026 Load 32'h1234ABCD -> digit0 seg=A1 an=FE, digit1 C6 an=FD, digit2 83, digit3 88, digit4 99, digit5 B0, digit6 A4, digit7 F9 an=7F; frame 40 cycles; next digit is 0.
REQ-027 One-cycle load of 32'h00000005 during cycle 2 of digit0 DISP -> seg C0->92 right after the edge; cnt and slot boundary unchanged; ack=1 for exactly the next cycle.
REQ-028 rst=1 together with load=1 during DISP of idx=5 -> next cycle an=FF, seg=FF, ack=0, shadow=0; then digit0 shows C0.
REQ-029 DISP_SCAN_LZB_EN defined, load 32'h000000A5 -> digits 0,1 show 92,88; digits 2..7 show seg=FF with an active. Without the macro: digits 2..7 show C0. Load 0 with the macro -> digit0 shows C0, others FF.
